// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator call-handling blocks.
package elevator_pkg;

    localparam int N_FLOORS_DEFAULT = 8;
    localparam int FLOOR_W_DEFAULT  = $clog2(N_FLOORS_DEFAULT);

    localparam int EDGE_TOGGLE = 0;
    localparam int EDGE_RISE   = 1;

    typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/call_debouncer.sv
// One call channel: synchroniser chain, stability counter and stable register,
// emitting single-cycle qualified rise/fall strobes.
module call_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arming_i,
    input  logic sw_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // While arming, track the input silently so a level present at power-up
    // is absorbed rather than reported as a call.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_o   = 1'b0;
        fall_o   = 1'b0;
        if (arming_i) begin
            stable_d = sync_out;
            cnt_d    = '0;
        end else if (sync_out == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_out;
            cnt_d    = '0;
            rise_o   = sync_out;
            fall_o   = ~sync_out;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/floor_request_latch.sv
// Floor-call register: debounced per-floor calls latched as pending requests,
// cleared on arrival, with summaries for the direction/scheduling FSM.
module floor_request_latch
    import elevator_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_DEFAULT,
    parameter int FLOOR_W         = $clog2(N_FLOORS),
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = EDGE_TOGGLE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_FLOORS-1:0]             sw,
    input  logic [FLOOR_W-1:0]              floor,
    input  logic                            arrive,
    input  logic                            clear_all,
    output logic [N_FLOORS-1:0]             pending,
    output logic                            req_here,
    output logic                            req_above,
    output logic                            req_below,
    output logic [$clog2(N_FLOORS+1)-1:0]   pending_count,
    output logic                            new_req
);

    localparam int CNT_W = $clog2(N_FLOORS + 1);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0]    arm_q;
    logic                arming;
    logic [N_FLOORS-1:0] rise, fall, events;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                new_req_q, new_req_d;
    logic [31:0]         floor_ext;

    assign arming    = (arm_q != '0);
    assign floor_ext = 32'(floor);

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_ch
        call_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .arming_i (arming),
            .sw_i     (sw[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g])
        );
    end

    assign events = (EDGE_MODE == EDGE_RISE) ? rise : (rise | fall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q     <= ARM_W'(SYNC_STAGES + 1);
            pending_q <= '0;
            count_q   <= '0;
            new_req_q <= 1'b0;
        end else begin
            if (arming) begin
                arm_q <= arm_q - ARM_W'(1);
            end
            pending_q <= pending_d;
            count_q   <= count_d;
            new_req_q <= new_req_d;
        end
    end

    // Priority: clear_all over arrival clear over new events.
    always_comb begin
        pending_d = pending_q | events;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (arrive && (32'(i) == floor_ext)) begin
                pending_d[i] = 1'b0;
            end
        end
        if (clear_all) begin
            pending_d = '0;
        end
        new_req_d = |(pending_d & ~pending_q);
        count_d   = CNT_W'(popcount32(32'(pending_d)));
    end

    // An out-of-range floor sits above every real floor, so all requests read as below.
    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (32'(i) == floor_ext) begin
                    req_here = 1'b1;
                end else if (32'(i) > floor_ext) begin
                    req_above = 1'b1;
                end else begin
                    req_below = 1'b1;
                end
            end
        end
    end

    assign pending       = pending_q;
    assign pending_count = count_q;
    assign new_req       = new_req_q;

endmodule

// File: tb/tb_floor_request_latch.sv
// Directed bench for floor_request_latch: toggle mode, rise mode and a 6-floor build.
module tb_floor_request_latch;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // toggle-mode, 8 floors
    logic [7:0] sw_a, pend_a;
    floor_t     floor_a;
    logic       arrive_a, clr_a, here_a, above_a, below_a, new_a;
    logic [3:0] cnt_a;

    // rise-mode, 8 floors
    logic [7:0] sw_r, pend_r;
    floor_t     floor_r;
    logic       arrive_r, clr_r, here_r, above_r, below_r, new_r;
    logic [3:0] cnt_r;

    // toggle-mode, 6 floors
    logic [5:0] sw_n, pend_n;
    logic [2:0] floor_n;
    logic       arrive_n, clr_n, here_n, above_n, below_n, new_n;
    logic [2:0] cnt_n;

    floor_request_latch #(.N_FLOORS(8), .EDGE_MODE(EDGE_TOGGLE)) dut (
        .clk(clk), .rst(rst), .sw(sw_a), .floor(floor_a), .arrive(arrive_a),
        .clear_all(clr_a), .pending(pend_a), .req_here(here_a), .req_above(above_a),
        .req_below(below_a), .pending_count(cnt_a), .new_req(new_a)
    );

    floor_request_latch #(.N_FLOORS(8), .EDGE_MODE(EDGE_RISE)) dut_r (
        .clk(clk), .rst(rst), .sw(sw_r), .floor(floor_r), .arrive(arrive_r),
        .clear_all(clr_r), .pending(pend_r), .req_here(here_r), .req_above(above_r),
        .req_below(below_r), .pending_count(cnt_r), .new_req(new_r)
    );

    floor_request_latch #(.N_FLOORS(6), .EDGE_MODE(EDGE_TOGGLE)) dut_n (
        .clk(clk), .rst(rst), .sw(sw_n), .floor(floor_n), .arrive(arrive_n),
        .clear_all(clr_n), .pending(pend_n), .req_here(here_n), .req_above(above_n),
        .req_below(below_n), .pending_count(cnt_n), .new_req(new_n)
    );

    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        sw_a = 8'hFF; floor_a = '0; arrive_a = 0; clr_a = 0;
        sw_r = 8'h00; floor_r = '0; arrive_r = 0; clr_r = 0;
        sw_n = 6'h00; floor_n = '0; arrive_n = 0; clr_n = 0;
        repeat (3) @(negedge clk);
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL reset_pending got %h exp 00", pend_a); end
        tests++; if (cnt_a !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", cnt_a); end
        tests++; if (new_a !== 1'b0) begin fails++; $display("FAIL reset_new_req got %b exp 0", new_a); end
        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (new_a) seen = 1;
        end
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL arm_pending got %h exp 00", pend_a); end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL arm_new_req got %b exp 0", seen); end
        rst = 1'b1;
        sw_a = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL rereset_pending got %h exp 00", pend_a); end
    endtask

    task automatic test_toggle_latency();
        bit seen;
        sw_a[3] = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL lat_early got %h exp 00", pend_a); end
        @(negedge clk);
        tests++; if (pend_a !== 8'h08) begin fails++; $display("FAIL lat_pending got %h exp 08", pend_a); end
        tests++; if (new_a !== 1'b1) begin fails++; $display("FAIL lat_new_req got %b exp 1", new_a); end
        tests++; if (cnt_a !== 4'd1) begin fails++; $display("FAIL lat_count got %0d exp 1", cnt_a); end
        @(negedge clk);
        tests++; if (new_a !== 1'b0) begin fails++; $display("FAIL lat_pulse_width got %b exp 0", new_a); end
        sw_a[3] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (new_a) seen = 1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL toggle_back_repulse got %b exp 0", seen); end
        tests++; if (pend_a !== 8'h08) begin fails++; $display("FAIL toggle_back_pending got %h exp 08", pend_a); end
    endtask

    task automatic test_glitch();
        bit seen;
        sw_a[5] = 1'b1;
        repeat (3) @(negedge clk);
        sw_a[5] = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (new_a) seen = 1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL glitch3_new_req got %b exp 0", seen); end
        tests++; if (pend_a !== 8'h08) begin fails++; $display("FAIL glitch3_pending got %h exp 08", pend_a); end
        sw_a[5] = 1'b1;
        repeat (4) @(negedge clk);
        sw_a[5] = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (pend_a !== 8'h28) begin fails++; $display("FAIL glitch4_pending got %h exp 28", pend_a); end
        tests++; if (new_a !== 1'b1) begin fails++; $display("FAIL glitch4_new_req got %b exp 1", new_a); end
        tests++; if (cnt_a !== 4'd2) begin fails++; $display("FAIL glitch4_count got %0d exp 2", cnt_a); end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (new_a) seen = 1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL glitch4_fall_repulse got %b exp 0", seen); end
    endtask

    task automatic test_clear_priority();
        sw_a[4] = ~sw_a[4];
        repeat (5) @(negedge clk);
        arrive_a = 1'b1; floor_a = 3'd4;
        @(negedge clk);
        arrive_a = 1'b0;
        tests++; if (pend_a !== 8'h28) begin fails++; $display("FAIL arrive_same_pending got %h exp 28", pend_a); end
        tests++; if (new_a !== 1'b0) begin fails++; $display("FAIL arrive_same_new_req got %b exp 0", new_a); end
        repeat (4) @(negedge clk);
        sw_a[1] = 1'b1;
        repeat (8) @(negedge clk);
        tests++; if (pend_a !== 8'h2A) begin fails++; $display("FAIL floor1_pending got %h exp 2a", pend_a); end
        sw_a[4] = ~sw_a[4];
        repeat (5) @(negedge clk);
        arrive_a = 1'b1; floor_a = 3'd1;
        @(negedge clk);
        arrive_a = 1'b0;
        tests++; if (pend_a !== 8'h38) begin fails++; $display("FAIL arrive_other_pending got %h exp 38", pend_a); end
        tests++; if (new_a !== 1'b1) begin fails++; $display("FAIL arrive_other_new_req got %b exp 1", new_a); end
        tests++; if (cnt_a !== 4'd3) begin fails++; $display("FAIL arrive_other_count got %0d exp 3", cnt_a); end
        repeat (4) @(negedge clk);
        sw_a[6] = 1'b1;
        repeat (5) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL clear_all_pending got %h exp 00", pend_a); end
        tests++; if (cnt_a !== 4'd0) begin fails++; $display("FAIL clear_all_count got %0d exp 0", cnt_a); end
        tests++; if (new_a !== 1'b0) begin fails++; $display("FAIL clear_all_new_req got %b exp 0", new_a); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_summaries();
        floor_a = 3'd3;
        #1;
        tests++; if ({here_a, above_a, below_a} !== 3'b000) begin fails++; $display("FAIL sum_empty got %b exp 000", {here_a, above_a, below_a}); end
        @(negedge clk);
        sw_a = sw_a ^ 8'h82;
        repeat (8) @(negedge clk);
        tests++; if (pend_a !== 8'h82) begin fails++; $display("FAIL sum_pending got %h exp 82", pend_a); end
        tests++; if (cnt_a !== 4'd2) begin fails++; $display("FAIL sum_count got %0d exp 2", cnt_a); end
        floor_a = 3'd4;
        #1;
        tests++; if ({here_a, above_a, below_a} !== 3'b011) begin fails++; $display("FAIL sum_floor4 got %b exp 011", {here_a, above_a, below_a}); end
        floor_a = 3'd7;
        #1;
        tests++; if ({here_a, above_a, below_a} !== 3'b101) begin fails++; $display("FAIL sum_floor7 got %b exp 101", {here_a, above_a, below_a}); end
        @(negedge clk);
        arrive_a = 1'b1;
        @(negedge clk);
        arrive_a = 1'b0;
        tests++; if (pend_a !== 8'h02) begin fails++; $display("FAIL arrive7_pending got %h exp 02", pend_a); end
        tests++; if (cnt_a !== 4'd1) begin fails++; $display("FAIL arrive7_count got %0d exp 1", cnt_a); end
        floor_a = 3'd0;
        #1;
        tests++; if ({here_a, above_a, below_a} !== 3'b010) begin fails++; $display("FAIL sum_floor0 got %b exp 010", {here_a, above_a, below_a}); end
        @(negedge clk);
    endtask

    task automatic test_rise_mode();
        bit seen;
        sw_r[2] = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (pend_r !== 8'h00) begin fails++; $display("FAIL rise_early got %h exp 00", pend_r); end
        @(negedge clk);
        tests++; if (pend_r !== 8'h04) begin fails++; $display("FAIL rise_pending got %h exp 04", pend_r); end
        tests++; if (new_r !== 1'b1) begin fails++; $display("FAIL rise_new_req got %b exp 1", new_r); end
        sw_r[2] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (new_r) seen = 1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rise_release_new_req got %b exp 0", seen); end
        tests++; if (pend_r !== 8'h04) begin fails++; $display("FAIL rise_release_pending got %h exp 04", pend_r); end
        arrive_r = 1'b1; floor_r = 3'd2;
        @(negedge clk);
        arrive_r = 1'b0;
        tests++; if (pend_r !== 8'h00) begin fails++; $display("FAIL rise_arrive_pending got %h exp 00", pend_r); end
        tests++; if (cnt_r !== 4'd0) begin fails++; $display("FAIL rise_arrive_count got %0d exp 0", cnt_r); end
    endtask

    task automatic test_narrow();
        sw_n[0] = 1'b1;
        repeat (8) @(negedge clk);
        tests++; if (pend_n !== 6'h01) begin fails++; $display("FAIL n6_pending got %h exp 01", pend_n); end
        tests++; if (cnt_n !== 3'd1) begin fails++; $display("FAIL n6_count got %0d exp 1", cnt_n); end
        floor_n = 3'd6;
        #1;
        tests++; if ({here_n, above_n, below_n} !== 3'b001) begin fails++; $display("FAIL n6_floor6 got %b exp 001", {here_n, above_n, below_n}); end
        @(negedge clk);
        arrive_n = 1'b1; floor_n = 3'd7;
        @(negedge clk);
        arrive_n = 1'b0;
        tests++; if (pend_n !== 6'h01) begin fails++; $display("FAIL n6_arrive_oob got %h exp 01", pend_n); end
        floor_n = 3'd0;
        #1;
        tests++; if ({here_n, above_n, below_n} !== 3'b100) begin fails++; $display("FAIL n6_floor0 got %b exp 100", {here_n, above_n, below_n}); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen;
        sw_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL async_rst_pending got %h exp 00", pend_a); end
        tests++; if (cnt_a !== 4'd0) begin fails++; $display("FAIL async_rst_count got %0d exp 0", cnt_a); end
        tests++; if ({here_a, above_a, below_a} !== 3'b000) begin fails++; $display("FAIL async_rst_summary got %b exp 000", {here_a, above_a, below_a}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (new_a) seen = 1;
        end
        tests++; if (pend_a !== 8'h00) begin fails++; $display("FAIL post_rst_pending got %h exp 00", pend_a); end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL post_rst_new_req got %b exp 0", seen); end
    endtask

    initial begin
        test_reset();
        test_toggle_latency();
        test_glitch();
        test_clear_priority();
        test_summaries();
        test_rise_mode();
        test_narrow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
